// File: rtl/ntt_twiddle_mul_seq.sv
// ntt_twiddle_mul_seq: multiplies the two butterfly differences by their twiddle
// factors with Barrett reduction mod IN_MODULUS, drives the twiddle BRAM address
// and delays the sum lanes so all four results leave together under one valid.
module ntt_twiddle_mul_seq #(
   parameter int unsigned               DATA_WIDTH    = 64,
   parameter int unsigned               MODULUS_WIDTH = 35,
   parameter logic [MODULUS_WIDTH-1:0]  IN_MODULUS    = 35'h4_0008_0001,
   parameter logic [MODULUS_WIDTH:0]    BARRETT_MU    = 36'hF_FFE0_003B,
   parameter int unsigned               TW_ADDR_WIDTH = 10
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_valid,
   input  logic                         i_clear,
   input  logic [TW_ADDR_WIDTH-1:0]     i_tw_stride,
   input  logic [DATA_WIDTH-1:0]        AC_sum,
   input  logic [DATA_WIDTH-1:0]        BD_sum,
   input  logic [MODULUS_WIDTH-1:0]     AC_sub,
   input  logic [MODULUS_WIDTH-1:0]     BD_sub,
   output logic [TW_ADDR_WIDTH-1:0]     o_tw_addr,
   input  logic [2*MODULUS_WIDTH-1:0]   i_tw_data,
   output logic                         o_valid,
   output logic [DATA_WIDTH-1:0]        o_AC_sum,
   output logic [DATA_WIDTH-1:0]        o_BD_sum,
   output logic [DATA_WIDTH-1:0]        o_AC_mul,
   output logic [DATA_WIDTH-1:0]        o_BD_mul
);

   localparam int MW  = MODULUS_WIDTH;
   localparam int PW  = 2 * MW;      // full product width
   localparam int QW  = MW + 1;      // width of q1, q3 and mu
   localparam int Q2W = 2 * QW;      // width of q1*mu
   localparam int RW  = MW + 2;      // remainder width, holds values < 3q
   localparam int LAT = 6;

   // Control state
   logic [TW_ADDR_WIDTH-1:0]       idx_d, idx_q, addr_d, addr_q;
   logic [LAT-1:0]                 vld_d, vld_q;
   logic                           o_valid_d, o_valid_q;

   // Arithmetic pipeline, lane 0 = AC, lane 1 = BD
   logic [1:0][MW-1:0]             sub_s, tw_s, sub1_d, sub1_q, sub2_d, sub2_q;
   logic [1:0][PW-1:0]             p_d, p_q;
   logic [1:0][RW-1:0]             p3_d, p3_q, r4_d, r4_q, r5_d, r5_q, r6_s;
   logic [1:0][QW-1:0]             q3_d, q3_q;
   logic [1:0][DATA_WIDTH-1:0]     mul_d, mul_q;

   // Sum lane delay line
   logic [LAT-1:0][DATA_WIDTH-1:0] ac_sr_d, ac_sr_q, bd_sr_d, bd_sr_q;
   logic [DATA_WIDTH-1:0]          ac_out_d, ac_out_q, bd_out_d, bd_out_q;

   // Twiddle index, address and valid chain next-state; clear wins for the next beat
   always_comb begin
      idx_d  = idx_q;
      addr_d = addr_q;
      if (i_valid) begin
         addr_d = idx_q;
      end else begin
         addr_d = addr_q;
      end
      if (i_clear) begin
         idx_d = '0;
      end else if (i_valid) begin
         idx_d = idx_q + i_tw_stride;
      end else begin
         idx_d = idx_q;
      end
      vld_d     = {vld_q[LAT-2:0], i_valid};
      o_valid_d = vld_q[LAT-1];
   end

   // Per-lane multiply and Barrett reduction; the remainder is exact in RW bits since it is < 3q
   always_comb begin
      sub_s = '0;
      tw_s  = '0;
      sub1_d = '0;
      sub2_d = '0;
      p_d   = '0;
      p3_d  = '0;
      q3_d  = '0;
      r4_d  = '0;
      r5_d  = '0;
      r6_s  = '0;
      mul_d = mul_q;
      sub_s[0] = AC_sub;
      sub_s[1] = BD_sub;
      tw_s[0]  = i_tw_data[MW-1:0];
      tw_s[1]  = i_tw_data[PW-1:MW];
      for (int l = 0; l < 2; l++) begin
         sub1_d[l] = sub_s[l];
         sub2_d[l] = sub1_q[l];          // waits out the BRAM read latency
         p_d[l]    = PW'(sub2_q[l]) * PW'(tw_s[l]);
         p3_d[l]   = p_q[l][RW-1:0];
         q3_d[l]   = QW'((Q2W'(p_q[l][PW-1:MW-1]) * Q2W'(BARRETT_MU)) >> (MW + 1));
         r4_d[l]   = p3_q[l] - (RW'(q3_q[l]) * RW'(IN_MODULUS));
         if (r4_q[l] >= RW'(IN_MODULUS)) begin
            r5_d[l] = r4_q[l] - RW'(IN_MODULUS);
         end else begin
            r5_d[l] = r4_q[l];
         end
         if (r5_q[l] >= RW'(IN_MODULUS)) begin
            r6_s[l] = r5_q[l] - RW'(IN_MODULUS);
         end else begin
            r6_s[l] = r5_q[l];
         end
         if (vld_q[LAT-1]) begin
            mul_d[l] = DATA_WIDTH'(r6_s[l]);
         end else begin
            mul_d[l] = mul_q[l];
         end
      end
   end

   // Sum lanes advance only where the valid chain carries a beat
   always_comb begin
      ac_sr_d = ac_sr_q;
      bd_sr_d = bd_sr_q;
      if (i_valid) begin
         ac_sr_d[0] = AC_sum;
         bd_sr_d[0] = BD_sum;
      end else begin
         ac_sr_d[0] = ac_sr_q[0];
         bd_sr_d[0] = bd_sr_q[0];
      end
      for (int k = 1; k < LAT; k++) begin
         if (vld_q[k-1]) begin
            ac_sr_d[k] = ac_sr_q[k-1];
            bd_sr_d[k] = bd_sr_q[k-1];
         end else begin
            ac_sr_d[k] = ac_sr_q[k];
            bd_sr_d[k] = bd_sr_q[k];
         end
      end
      if (vld_q[LAT-1]) begin
         ac_out_d = ac_sr_q[LAT-1];
         bd_out_d = bd_sr_q[LAT-1];
      end else begin
         ac_out_d = ac_out_q;
         bd_out_d = bd_out_q;
      end
   end

   // Control and output registers, cleared by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q     <= '0;
         addr_q    <= '0;
         vld_q     <= '0;
         o_valid_q <= 1'b0;
         mul_q     <= '0;
         ac_out_q  <= '0;
         bd_out_q  <= '0;
      end else begin
         idx_q     <= idx_d;
         addr_q    <= addr_d;
         vld_q     <= vld_d;
         o_valid_q <= o_valid_d;
         mul_q     <= mul_d;
         ac_out_q  <= ac_out_d;
         bd_out_q  <= bd_out_d;
      end
   end

   // Data pipeline registers, qualified by the valid chain so no reset is needed
   always_ff @(posedge clk) begin
      sub1_q  <= sub1_d;
      sub2_q  <= sub2_d;
      p_q     <= p_d;
      p3_q    <= p3_d;
      q3_q    <= q3_d;
      r4_q    <= r4_d;
      r5_q    <= r5_d;
      ac_sr_q <= ac_sr_d;
      bd_sr_q <= bd_sr_d;
   end

   assign o_tw_addr = addr_q;
   assign o_valid   = o_valid_q;
   assign o_AC_mul  = mul_q[0];
   assign o_BD_mul  = mul_q[1];
   assign o_AC_sum  = ac_out_q;
   assign o_BD_sum  = bd_out_q;

endmodule

// File: tb/tb_ntt_twiddle_mul_seq.sv
// tb_ntt_twiddle_mul_seq: directed and randomized checks against a latency-queue
// reference model that computes (sub*tw) mod q directly.
module tb_ntt_twiddle_mul_seq;

   localparam int          DW  = 64;
   localparam int          MW  = 35;
   localparam int          TAW = 4;
   localparam logic [34:0] Q   = 35'h4_0008_0001;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           i_valid = 1'b0;
   logic           i_clear = 1'b0;
   logic [TAW-1:0] i_tw_stride = 4'd5;
   logic [DW-1:0]  AC_sum = 64'd0, BD_sum = 64'd0;
   logic [MW-1:0]  AC_sub = 35'd0, BD_sub = 35'd0;
   logic [TAW-1:0] o_tw_addr;
   logic [2*MW-1:0] tw_data;
   logic           o_valid;
   logic [DW-1:0]  o_AC_sum, o_BD_sum, o_AC_mul, o_BD_mul;

   int n_chk  = 0;
   int n_fail = 0;

   logic [2*MW-1:0] mem [16];

   ntt_twiddle_mul_seq #(
      .DATA_WIDTH(DW), .MODULUS_WIDTH(MW), .IN_MODULUS(Q),
      .BARRETT_MU(36'hF_FFE0_003B), .TW_ADDR_WIDTH(TAW)
   ) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_clear(i_clear),
      .i_tw_stride(i_tw_stride), .AC_sum(AC_sum), .BD_sum(BD_sum),
      .AC_sub(AC_sub), .BD_sub(BD_sub), .o_tw_addr(o_tw_addr),
      .i_tw_data(tw_data), .o_valid(o_valid), .o_AC_sum(o_AC_sum),
      .o_BD_sum(o_BD_sum), .o_AC_mul(o_AC_mul), .o_BD_mul(o_BD_mul)
   );

   always #5 clk = ~clk;

   // Twiddle BRAM: data one cycle after the address
   always @(posedge clk) tw_data <= mem[o_tw_addr];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] mulmod(input logic [34:0] a, input logic [34:0] b);
      logic [127:0] t;
      t = 128'(a) * 128'(b);
      return 64'(t % 128'(Q));
   endfunction

   function automatic logic [34:0] rnd_res();
      logic [63:0] t;
      int sel;
      sel = $urandom_range(15);
      t = {$urandom, $urandom};
      if (sel == 0) return 35'd0;
      else if (sel == 1) return Q - 35'd1;
      else return 35'(t % 64'(Q));
   endfunction

   // Reference model: beats ride a 7-entry latency queue; outputs hold between beats
   logic           pv  [7];
   logic [63:0]    pac [7], pbd [7], psa [7], psb [7];
   logic [63:0]    hac = 64'd0, hbd = 64'd0, hsa = 64'd0, hsb = 64'd0;
   logic [TAW-1:0] m_idx = 4'd0, m_addr = 4'd0;
   logic [2*MW-1:0] m_tw;

   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 7; k++) pv[k] = 1'b0;
         hac = 64'd0; hbd = 64'd0; hsa = 64'd0; hsb = 64'd0;
         m_idx = 4'd0; m_addr = 4'd0;
      end else begin
         for (int k = 6; k > 0; k--) begin
            pv[k] = pv[k-1]; pac[k] = pac[k-1]; pbd[k] = pbd[k-1];
            psa[k] = psa[k-1]; psb[k] = psb[k-1];
         end
         pv[0] = i_valid;
         if (i_valid) begin
            m_tw   = mem[m_idx];
            pac[0] = mulmod(AC_sub, m_tw[34:0]);
            pbd[0] = mulmod(BD_sub, m_tw[69:35]);
            psa[0] = AC_sum;
            psb[0] = BD_sum;
            m_addr = m_idx;
            m_idx  = m_idx + i_tw_stride;
         end
         if (i_clear) m_idx = 4'd0;
         if (pv[6]) begin
            hac = pac[6]; hbd = pbd[6]; hsa = psa[6]; hsb = psb[6];
         end
      end
      #1;
      chk("m_valid", 64'(o_valid), 64'(pv[6]));
      chk("m_addr", 64'(o_tw_addr), 64'(m_addr));
      chk("m_ac_mul", o_AC_mul, hac);
      chk("m_bd_mul", o_BD_mul, hbd);
      chk("m_ac_sum", o_AC_sum, hsa);
      chk("m_bd_sum", o_BD_sum, hsb);
   end

   // One isolated beat from index 0, checked exactly at latency 6
   task automatic run_one(input string tag, input logic [34:0] a, input logic [34:0] b,
                          input logic [34:0] tac, input logic [34:0] tbd,
                          input logic [63:0] eac, input logic [63:0] ebd);
      logic [63:0] sa, sb;
      sa = {$urandom, $urandom};
      sb = {$urandom, $urandom};
      @(negedge clk);
      i_valid = 1'b0; i_clear = 1'b1; mem[0] = {tbd, tac};
      @(negedge clk);
      i_clear = 1'b0; i_valid = 1'b1; AC_sub = a; BD_sub = b; AC_sum = sa; BD_sum = sb;
      @(negedge clk);
      i_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      chk({tag, "_early"}, 64'(o_valid), 64'd0);
      @(posedge clk);
      #2;
      chk({tag, "_valid"}, 64'(o_valid), 64'd1);
      chk({tag, "_ac_mul"}, o_AC_mul, eac);
      chk({tag, "_bd_mul"}, o_BD_mul, ebd);
      chk({tag, "_ac_sum"}, o_AC_sum, sa);
      chk({tag, "_bd_sum"}, o_BD_sum, sb);
      chk({tag, "_addr"}, 64'(o_tw_addr), 64'd0);
   endtask

   initial begin
      logic [TAW-1:0] exp_wrap [5];
      logic [TAW-1:0] exp_clr  [4];
      logic           pat      [6];
      exp_wrap = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd4};
      exp_clr  = '{4'd0, 4'd5, 4'd10, 4'd0};
      pat      = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 16; i++) mem[i] = {rnd_res(), rnd_res()};

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_addr", 64'(o_tw_addr), 64'd0);
      chk("rst_ac_mul", o_AC_mul, 64'd0);
      chk("rst_bd_sum", o_BD_sum, 64'd0);
      rst = 1'b0;

      run_one("basic", 35'd2, 35'd5, 35'd3, 35'd7, 64'd6, 64'd35);
      run_one("worst", Q - 35'd1, Q - 35'd1, Q - 35'd1, Q - 35'd1, 64'd1, 64'd1);
      run_one("tw0", 35'h1_2345_6789, 35'h3_FFFF_0000, 35'd0, 35'd0, 64'd0, 64'd0);
      run_one("tw1", 35'h1_2345_6789, 35'h3_FFFF_0000, 35'd1, 35'd1,
              64'h1_2345_6789, 64'h3_FFFF_0000);

      // Address wrap with stride 5
      @(negedge clk);
      i_clear = 1'b1; i_tw_stride = 4'd5;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         i_clear = 1'b0; i_valid = 1'b1; AC_sub = rnd_res(); BD_sub = rnd_res();
         @(posedge clk);
         #2;
         chk("wrap_addr", 64'(o_tw_addr), 64'(exp_wrap[i]));
      end
      @(negedge clk);
      i_valid = 1'b0; i_clear = 1'b1;
      // Clear alongside the third beat
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         i_valid = 1'b1; i_clear = (i == 2); AC_sub = rnd_res(); BD_sub = rnd_res();
         @(posedge clk);
         #2;
         chk("clr_addr", 64'(o_tw_addr), 64'(exp_clr[i]));
      end
      @(negedge clk);
      i_valid = 1'b0; i_clear = 1'b0;
      repeat (8) @(negedge clk);

      // Bubble pattern V,-,V,V,-,V reappears six cycles later
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         i_valid = pat[i]; AC_sub = rnd_res(); BD_sub = rnd_res();
         AC_sum = {$urandom, $urandom}; BD_sum = {$urandom, $urandom};
      end
      @(negedge clk);
      i_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #2;
         chk("bubble_valid", 64'(o_valid), 64'(pat[i]));
      end
      repeat (4) @(negedge clk);

      // Randomized stream
      for (int i = 0; i < 16; i++) mem[i] = {rnd_res(), rnd_res()};
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         i_valid     = ($urandom_range(3) != 0);
         i_clear     = ($urandom_range(31) == 0);
         i_tw_stride = 4'($urandom_range(15));
         AC_sub = rnd_res(); BD_sub = rnd_res();
         AC_sum = {$urandom, $urandom}; BD_sum = {$urandom, $urandom};
      end
      @(negedge clk);
      i_valid = 1'b0; i_clear = 1'b0;
      repeat (10) @(negedge clk);

      // Reset with four beats in flight
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         i_valid = 1'b1; AC_sub = rnd_res(); BD_sub = rnd_res();
         AC_sum = {$urandom, $urandom}; BD_sum = {$urandom, $urandom};
      end
      @(negedge clk);
      i_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #2;
         chk("mrst_valid", 64'(o_valid), 64'd0);
         chk("mrst_ac_mul", o_AC_mul, 64'd0);
         chk("mrst_ac_sum", o_AC_sum, 64'd0);
      end
      run_one("post_rst", 35'd11, 35'd13, 35'd17, 35'd19, 64'd187, 64'd247);
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
